// File: rtl/gpr_wb_sched.sv
// Register-file write-back scheduler: EX2 writes pass straight through, while load and
// MUL/DIV results queue in a small FIFO that drains whenever the write port is free.
module gpr_wb_sched #(
  parameter int          DEPTH  = 4,
  parameter int          STARVE = 4,
  parameter logic [5:0]  ZZR_ID = 6'h3F
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     hold,
  input  logic [5:0]               exIdRn,
  input  logic [63:0]              exValRn,
  input  logic                     ldValid,
  output logic                     ldReady,
  input  logic [5:0]               ldIdRn,
  input  logic [63:0]              ldValRn,
  input  logic                     mdValid,
  output logic                     mdReady,
  input  logic [5:0]               mdIdRn,
  input  logic [63:0]              mdValRn,
  input  logic [5:0]               regIdRs,
  input  logic [5:0]               regIdRt,
  input  logic [5:0]               regIdRm,
  output logic [5:0]               wbIdRn,
  output logic [63:0]              wbValRn,
  output logic                     holdOut,
  output logic [$clog2(DEPTH):0]   qCount
);

  localparam logic [5:0] IMM_ID = 6'h3E;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE + 1);

  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] ent_live;
  logic [5:0]       ent_id  [DEPTH];
  logic [63:0]      ent_val [DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW:0]      count;
  logic [CW-1:0]    starve_cnt;

  logic        run;
  logic        nonempty;
  logic        head_live;
  logic        starve;
  logic        hazard;
  logic        ex_go;
  logic        deq;
  logic        enq;
  logic        blocked;
  logic        ld_fire;
  logic        md_fire;
  logic [5:0]  enq_id;
  logic [63:0] enq_val;
  logic        rs_chk;
  logic        rt_chk;
  logic        rm_chk;

  assign qCount = count;

  always_comb begin
    run       = reset & ~hold;
    nonempty  = (count != '0);
    head_live = ent_valid[head] & ent_live[head];
    starve    = (starve_cnt >= CW'(STARVE));

    rs_chk = (regIdRs != ZZR_ID) && (regIdRs != IMM_ID);
    rt_chk = (regIdRt != ZZR_ID) && (regIdRt != IMM_ID);
    rm_chk = (regIdRm != ZZR_ID) && (regIdRm != IMM_ID);
    hazard = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[AW'(i)] && ent_live[AW'(i)] &&
          ((rs_chk && ent_id[AW'(i)] == regIdRs) ||
           (rt_chk && ent_id[AW'(i)] == regIdRt) ||
           (rm_chk && ent_id[AW'(i)] == regIdRm)))
        hazard = 1'b1;
    end
    holdOut = starve | hazard;

    ex_go   = run && (exIdRn != ZZR_ID) && !holdOut;
    // A dead head never needs the port, so it retires even while EX2 writes.
    deq     = run && nonempty && (!head_live || !ex_go);
    blocked = run && nonempty && head_live && ex_go;

    ldReady = run && (count < (AW+1)'(DEPTH));
    mdReady = ldReady & ~ldValid;
    ld_fire = ldValid & ldReady;
    md_fire = mdValid & mdReady;
    enq_id  = ld_fire ? ldIdRn  : mdIdRn;
    enq_val = ld_fire ? ldValRn : mdValRn;
    enq     = (ld_fire && ldIdRn != ZZR_ID) || (md_fire && mdIdRn != ZZR_ID);

    wbIdRn  = ZZR_ID;
    wbValRn = '0;
    if (ex_go) begin
      wbIdRn  = exIdRn;
      wbValRn = exValRn;
    end else if (deq && head_live) begin
      wbIdRn  = ent_id[head];
      wbValRn = ent_val[head];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ent_valid  <= '0;
      ent_live   <= '0;
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      starve_cnt <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_id[AW'(i)]  <= ZZR_ID;
        ent_val[AW'(i)] <= '0;
      end
    end else if (run) begin
      // Kill pass runs before the enqueue write so a same-cycle newcomer stays live.
      if (ex_go) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (ent_valid[AW'(i)] && ent_id[AW'(i)] == exIdRn)
            ent_live[AW'(i)] <= 1'b0;
        end
      end
      if (deq) begin
        ent_valid[head] <= 1'b0;
        ent_live[head]  <= 1'b0;
        head            <= head + AW'(1);
      end
      if (enq) begin
        ent_valid[tail] <= 1'b1;
        ent_live[tail]  <= 1'b1;
        ent_id[tail]    <= enq_id;
        ent_val[tail]   <= enq_val;
        tail            <= tail + AW'(1);
      end
      count <= count + (AW+1)'(enq) - (AW+1)'(deq);

      if (deq || !nonempty)
        starve_cnt <= '0;
      else if (blocked && !starve)
        starve_cnt <= starve_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_gpr_wb_sched.sv
// Directed bench for gpr_wb_sched: hand-computed write-port, ready, stall and count values.
module tb_gpr_wb_sched;

  localparam logic [5:0] ZZR = 6'h3F;
  localparam logic [5:0] IMM = 6'h3E;

  logic        clock;
  logic        reset;
  logic        hold;
  logic [5:0]  exIdRn;
  logic [63:0] exValRn;
  logic        ldValid;
  logic        ldReady;
  logic [5:0]  ldIdRn;
  logic [63:0] ldValRn;
  logic        mdValid;
  logic        mdReady;
  logic [5:0]  mdIdRn;
  logic [63:0] mdValRn;
  logic [5:0]  regIdRs;
  logic [5:0]  regIdRt;
  logic [5:0]  regIdRm;
  logic [5:0]  wbIdRn;
  logic [63:0] wbValRn;
  logic        holdOut;
  logic [2:0]  qCount;

  int n_chk  = 0;
  int n_fail = 0;

  gpr_wb_sched #(.DEPTH(4), .STARVE(4), .ZZR_ID(ZZR)) dut (
    .clock(clock), .reset(reset), .hold(hold),
    .exIdRn(exIdRn), .exValRn(exValRn),
    .ldValid(ldValid), .ldReady(ldReady), .ldIdRn(ldIdRn), .ldValRn(ldValRn),
    .mdValid(mdValid), .mdReady(mdReady), .mdIdRn(mdIdRn), .mdValRn(mdValRn),
    .regIdRs(regIdRs), .regIdRt(regIdRt), .regIdRm(regIdRm),
    .wbIdRn(wbIdRn), .wbValRn(wbValRn), .holdOut(holdOut), .qCount(qCount)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0; hold = 1'b0;
    exIdRn = ZZR; exValRn = '0;
    ldValid = 1'b0; ldIdRn = ZZR; ldValRn = '0;
    mdValid = 1'b0; mdIdRn = ZZR; mdValRn = '0;
    regIdRs = ZZR; regIdRt = ZZR; regIdRm = ZZR;

    // Reset state
    #2;
    chk("rst_qcount", qCount, 0);
    chk("rst_holdout", holdOut, 0);
    chk("rst_ldready", ldReady, 0);
    chk("rst_mdready", mdReady, 0);
    chk("rst_wbid", wbIdRn, ZZR);
    chk("rst_wbval", wbValRn, 0);
    tick();
    reset = 1'b1;
    tick();

    // EX2 pass-through
    exIdRn = 6'd5; exValRn = 64'h1234; #1;
    chk("ex_wbid", wbIdRn, 5);
    chk("ex_wbval", wbValRn, 64'h1234);
    chk("ex_qcount", qCount, 0);
    tick();

    // Load beats MD; each reaches the port one cycle after acceptance
    exIdRn = ZZR;
    ldValid = 1'b1; ldIdRn = 6'd10; ldValRn = 64'hA0;
    mdValid = 1'b1; mdIdRn = 6'd11; mdValRn = 64'hB1; #1;
    chk("prio_ldready", ldReady, 1);
    chk("prio_mdready", mdReady, 0);
    chk("prio_wbid_n", wbIdRn, ZZR);
    tick();
    ldValid = 1'b0; #1;
    chk("prio_qcount_n1", qCount, 1);
    chk("prio_wbid_n1", wbIdRn, 10);
    chk("prio_wbval_n1", wbValRn, 64'hA0);
    chk("prio_mdready_n1", mdReady, 1);
    tick();
    mdValid = 1'b0; #1;
    chk("prio_qcount_n2", qCount, 1);
    chk("prio_wbid_n2", wbIdRn, 11);
    chk("prio_wbval_n2", wbValRn, 64'hB1);
    tick();
    chk("prio_qcount_n3", qCount, 0);
    chk("prio_wbid_n3", wbIdRn, ZZR);

    // Fill under continuous EX2 writes, starvation stall, FIFO drain
    exIdRn = 6'd20; exValRn = 64'h2000;
    for (int k = 1; k <= 4; k++) begin
      ldValid = 1'b1; ldIdRn = 6'(k); ldValRn = 64'h100 + 64'(k); #1;
      chk("fill_wbid_ex", wbIdRn, 20);
      chk("fill_holdout", holdOut, 0);
      tick();
    end
    ldValid = 1'b0; #1;
    chk("full_qcount", qCount, 4);
    chk("full_ldready", ldReady, 0);
    chk("full_holdout", holdOut, 0);
    chk("full_wbid_ex", wbIdRn, 20);
    tick();
    chk("starve_holdout", holdOut, 1);
    chk("starve_wbid", wbIdRn, 1);
    chk("starve_wbval", wbValRn, 64'h101);
    tick();
    exIdRn = ZZR; #1;
    chk("drain_holdout", holdOut, 0);
    chk("drain_qcount", qCount, 3);
    chk("drain_wbid2", wbIdRn, 2);
    chk("drain_wbval2", wbValRn, 64'h102);
    tick();
    chk("drain_wbid3", wbIdRn, 3);
    tick();
    chk("drain_wbid4", wbIdRn, 4);
    chk("drain_wbval4", wbValRn, 64'h104);
    tick();
    chk("drain_qcount_end", qCount, 0);
    chk("drain_wbid_end", wbIdRn, ZZR);

    // EX2 overwrite kills queued id 7; a same-cycle id-7 enqueue survives
    ldValid = 1'b1; ldIdRn = 6'd7; ldValRn = 64'h77;
    tick();
    ldValRn = 64'h78;
    exIdRn = 6'd7; exValRn = 64'hE7; #1;
    chk("kill_wbid_ex", wbIdRn, 7);
    chk("kill_wbval_ex", wbValRn, 64'hE7);
    chk("kill_qcount", qCount, 1);
    tick();
    ldValid = 1'b0; exIdRn = ZZR; #1;
    chk("kill_qcount2", qCount, 2);
    chk("kill_dead_wbid", wbIdRn, ZZR);
    chk("kill_dead_wbval", wbValRn, 0);
    tick();
    chk("kill_new_wbid", wbIdRn, 7);
    chk("kill_new_wbval", wbValRn, 64'h78);
    tick();
    chk("kill_qcount_end", qCount, 0);

    // Source hazard; IMM id is never a hazard; hold freezes everything
    regIdRs = IMM; regIdRt = 6'd9;
    ldValid = 1'b1; ldIdRn = IMM; ldValRn = 64'h62; #1;
    chk("haz_empty_holdout", holdOut, 0);
    tick();
    ldIdRn = 6'd9; ldValRn = 64'h99; #1;
    chk("haz_imm_holdout", holdOut, 0);
    chk("haz_imm_wbid", wbIdRn, IMM);
    tick();
    ldValid = 1'b0; hold = 1'b1; #1;
    chk("hold_holdout", holdOut, 1);
    chk("hold_ldready", ldReady, 0);
    chk("hold_wbid", wbIdRn, ZZR);
    tick();
    hold = 1'b0;
    exIdRn = 6'd30; exValRn = 64'h30; #1;
    chk("hold_qcount", qCount, 1);
    chk("haz_holdout", holdOut, 1);
    chk("haz_wbid", wbIdRn, 9);
    chk("haz_wbval", wbValRn, 64'h99);
    tick();
    chk("haz_clear_holdout", holdOut, 0);
    chk("haz_clear_wbid", wbIdRn, 30);
    regIdRs = ZZR; regIdRt = ZZR;

    // Asynchronous reset with a partly filled queue
    exIdRn = 6'd40; exValRn = 64'h40;
    for (int k = 0; k < 3; k++) begin
      ldValid = 1'b1; ldIdRn = 6'(50 + k); ldValRn = 64'h500 + 64'(k);
      tick();
    end
    ldValid = 1'b0; #1;
    chk("arst_pre_qcount", qCount, 3);
    reset = 1'b0; #1;
    chk("arst_qcount", qCount, 0);
    chk("arst_holdout", holdOut, 0);
    chk("arst_wbid", wbIdRn, ZZR);
    chk("arst_ldready", ldReady, 0);
    exIdRn = ZZR; #1;
    reset = 1'b1;
    tick();
    chk("arst_post_qcount", qCount, 0);
    chk("arst_post_wbid", wbIdRn, ZZR);
    tick();
    chk("arst_post2_wbid", wbIdRn, ZZR);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
